// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle DIV/DIVU unit: state codes,
// handshake levels and a two's-complement negate helper.
package div_unit_pkg;

  // Divider control states (2-bit encoding)
  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  // One quotient bit per step, 32 steps; counter is 6 bits wide
  localparam int unsigned CNT_W     = 6;
  localparam logic [CNT_W-1:0] DIV_STEPS = 6'd32;

  // Two's-complement negate of a 32-bit word
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return (~v) + 32'd1;
  endfunction

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU. Operands are latched on start,
// magnitudes are divided one quotient bit per cycle, and signs are fixed
// up on the final cycle. result_o = {remainder, quotient}.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  div_state_e              state_r, state_nxt_s;
  logic [CNT_W-1:0]        cnt_r, cnt_nxt_s;
  logic [2*DATA_W:0]       work_r, work_nxt_s;
  logic [DATA_W-1:0]       divisor_r, divisor_nxt_s;
  logic                    signed_r, signed_nxt_s;
  logic                    sign1_r, sign1_nxt_s;
  logic                    sign2_r, sign2_nxt_s;
  logic [2*DATA_W-1:0]     result_nxt_s;
  logic                    ready_nxt_s;

  logic                    go_s;
  logic [DATA_W-1:0]       abs1_s, abs2_s;
  logic [DATA_W:0]         trial_s;
  logic [DATA_W-1:0]       quot_s, rem_s, quot_fix_s, rem_fix_s;

  // A request is taken only when not being flushed in the same cycle
  assign go_s = (start_i == DIV_START) && !annul_i;

  // Operand magnitudes: negate only for signed divides with the MSB set
  assign abs1_s = (signed_div_i && opdata1_i[DATA_W-1]) ? neg32(opdata1_i) : opdata1_i;
  assign abs2_s = (signed_div_i && opdata2_i[DATA_W-1]) ? neg32(opdata2_i) : opdata2_i;

  // Trial subtraction of the divisor from the current partial remainder
  assign trial_s = {1'b0, work_r[2*DATA_W-1:DATA_W]} - {1'b0, divisor_r};

  // Unsigned result fields and their signed fix-up
  assign quot_s     = work_r[DATA_W-1:0];
  assign rem_s      = work_r[2*DATA_W:DATA_W+1];
  assign quot_fix_s = (signed_r && (sign1_r ^ sign2_r)) ? neg32(quot_s) : quot_s;
  assign rem_fix_s  = (signed_r && sign1_r) ? neg32(rem_s) : rem_s;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= DIV_FREE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state selection
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      DIV_FREE: begin
        if (go_s) begin
          if (opdata2_i == 32'd0) begin
            state_nxt_s = DIV_BY_ZERO;
          end else begin
            state_nxt_s = DIV_ON;
          end
        end else begin
          state_nxt_s = DIV_FREE;
        end
      end
      DIV_BY_ZERO: begin
        if (annul_i) begin
          state_nxt_s = DIV_FREE;
        end else begin
          state_nxt_s = DIV_END;
        end
      end
      DIV_ON: begin
        if (annul_i) begin
          state_nxt_s = DIV_FREE;
        end else if (cnt_r == DIV_STEPS) begin
          state_nxt_s = DIV_END;
        end else begin
          state_nxt_s = DIV_ON;
        end
      end
      DIV_END: begin
        if (start_i == DIV_STOP) begin
          state_nxt_s = DIV_FREE;
        end else begin
          state_nxt_s = DIV_END;
        end
      end
      default: state_nxt_s = DIV_FREE;
    endcase
  end

  // Datapath and output next values for each state
  always_comb begin
    cnt_nxt_s     = cnt_r;
    work_nxt_s    = work_r;
    divisor_nxt_s = divisor_r;
    signed_nxt_s  = signed_r;
    sign1_nxt_s   = sign1_r;
    sign2_nxt_s   = sign2_r;
    result_nxt_s  = result_o;
    ready_nxt_s   = ready_o;
    case (state_r)
      DIV_FREE: begin
        result_nxt_s = 64'd0;
        ready_nxt_s  = DIV_RESULT_NOT_READY;
        if (go_s && (opdata2_i != 32'd0)) begin
          signed_nxt_s  = signed_div_i;
          sign1_nxt_s   = opdata1_i[DATA_W-1];
          sign2_nxt_s   = opdata2_i[DATA_W-1];
          divisor_nxt_s = abs2_s;
          work_nxt_s    = {32'd0, abs1_s, 1'b0};
          cnt_nxt_s     = 6'd0;
        end else begin
          cnt_nxt_s     = cnt_r;
        end
      end
      DIV_BY_ZERO: begin
        if (annul_i) begin
          ready_nxt_s  = DIV_RESULT_NOT_READY;
        end else begin
          result_nxt_s = 64'd0;
          ready_nxt_s  = DIV_RESULT_READY;
        end
      end
      DIV_ON: begin
        if (annul_i) begin
          ready_nxt_s = DIV_RESULT_NOT_READY;
        end else if (cnt_r != DIV_STEPS) begin
          if (trial_s[DATA_W]) begin
            work_nxt_s = {work_r[2*DATA_W-1:0], 1'b0};
          end else begin
            work_nxt_s = {trial_s[DATA_W-1:0], work_r[DATA_W-1:0], 1'b1};
          end
          cnt_nxt_s = cnt_r + 6'd1;
        end else begin
          result_nxt_s = {rem_fix_s, quot_fix_s};
          ready_nxt_s  = DIV_RESULT_READY;
        end
      end
      DIV_END: begin
        if (start_i == DIV_STOP) begin
          result_nxt_s = 64'd0;
          ready_nxt_s  = DIV_RESULT_NOT_READY;
        end else begin
          ready_nxt_s  = ready_o;
        end
      end
      default: begin
        result_nxt_s = 64'd0;
        ready_nxt_s  = DIV_RESULT_NOT_READY;
      end
    endcase
  end

  // Datapath and registered outputs; reset drops any partial result at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r     <= 6'd0;
      work_r    <= 65'd0;
      divisor_r <= 32'd0;
      signed_r  <= 1'b0;
      sign1_r   <= 1'b0;
      sign2_r   <= 1'b0;
      result_o  <= 64'd0;
      ready_o   <= DIV_RESULT_NOT_READY;
    end else begin
      cnt_r     <= cnt_nxt_s;
      work_r    <= work_nxt_s;
      divisor_r <= divisor_nxt_s;
      signed_r  <= signed_nxt_s;
      sign1_r   <= sign1_nxt_s;
      sign2_r   <= sign2_nxt_s;
      result_o  <= result_nxt_s;
      ready_o   <= ready_nxt_s;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: a vector table, randomized divides
// against a 64-bit arithmetic model, and hand-written annul/reset/hold cases.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] sb_q[$];

  typedef struct {
    logic        sd;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  div_unit #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: exact 64-bit arithmetic (truncating division, remainder sign of dividend)
  function automatic logic [63:0] model(input logic sd, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    sa = sd ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sd ? longint'($signed(b)) : longint'({32'd0, b});
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic issue(input logic sd, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    signed_div_i = sd;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
  endtask

  task automatic wait_ready(output int lat, output bit got);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      got = ready_o;
    end
  endtask

  task automatic finish_div(input string name);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({name, " drop ready"}, 64'(ready_o), 64'd0);
    check({name, " drop result"}, result_o, 64'd0);
  endtask

  task automatic run_div(input string name, input logic sd, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
    int lat;
    bit got;
    logic [63:0] e;
    sb_q.push_back(exp);
    issue(sd, a, b);
    wait_ready(lat, got);
    check({name, " ready"}, 64'(got), 64'd1);
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    e = sb_q.pop_front();
    check({name, " result"}, result_o, e);
    finish_div(name);
  endtask

  initial begin
    int lat;
    bit got;
    bit rose;
    logic        sd;
    logic [31:0] a, b;

    vecs[0] = '{1'b0, 32'hFFFFFFFF, 32'h00000010, 64'h0000000F_0FFFFFFF, 34};
    vecs[1] = '{1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 34};
    vecs[2] = '{1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34};
    vecs[3] = '{1'b1, 32'h12345678, 32'h00000000, 64'h00000000_00000000, 2};
    vecs[4] = '{1'b0, 32'd100,      32'd7,        64'h00000002_0000000E, 34};
    vecs[5] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34};
    vecs[6] = '{1'b0, 32'd5,        32'd9,        64'h00000005_00000000, 34};
    vecs[7] = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 34};
    vecs[8] = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 34};
    vecs[9] = '{1'b0, 32'd0,        32'd0,        64'h00000000_00000000, 2};

    rst = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd0; opdata2_i = 32'd0;
    start_i = 1'b0; annul_i = 1'b0;
    #3;
    check("reset result", result_o, 64'd0);
    check("reset ready", 64'(ready_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table vectors
    for (int i = 0; i < 10; i++) begin
      run_div($sformatf("vec%0d", i), vecs[i].sd, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    end

    // Random divides against the model
    for (int i = 0; i < 8; i++) begin
      sd = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = (i % 2 == 1) ? 32'($urandom_range(1, 255)) : $urandom;
      if (i == 6) b = ~b + 32'd1;
      run_div($sformatf("rand%0d", i), sd, a, b, model(sd, a, b), (b == 32'd0) ? 2 : 34);
    end

    // Annul at edge 10: no result, then a fresh divide completes normally
    issue(1'b0, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    check("annul ready", 64'(ready_o), 64'd0);
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    rose = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready_o) rose = 1'b1;
    end
    check("annul never ready", 64'(rose), 64'd0);
    run_div("after annul", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34);

    // Async reset at edge 20 of a divide
    issue(1'b0, 32'hDEADBEEF, 32'd3);
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midreset result", result_o, 64'd0);
    check("midreset ready", 64'(ready_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    start_i = 1'b0;
    run_div("post reset ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34);

    // Async reset while a result is being held clears it before any edge
    issue(1'b0, 32'd100, 32'd7);
    wait_ready(lat, got);
    check("end ready", 64'(got), 64'd1);
    check("end result", result_o, 64'h00000002_0000000E);
    #2 rst = 1'b1;
    #1;
    check("endreset result", result_o, 64'd0);
    check("endreset ready", 64'(ready_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    start_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("endreset idle", 64'(ready_o), 64'd0);

    // Operand changes during the divide are ignored; result held in DivEnd
    sb_q.push_back(64'hFFFFFFFF_FFFFFFFD);
    issue(1'b1, 32'hFFFFFFF9, 32'd2);
    repeat (5) @(posedge clk);
    @(negedge clk);
    opdata1_i = 32'd12345;
    opdata2_i = 32'd0;
    signed_div_i = 1'b0;
    wait_ready(lat, got);
    check("hold ready", 64'(got), 64'd1);
    check("hold latency", 64'(lat), 64'd29);
    check("hold result", result_o, sb_q.pop_front());
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold%0d ready", k), 64'(ready_o), 64'd1);
      check($sformatf("hold%0d result", k), result_o, 64'hFFFFFFFF_FFFFFFFD);
    end
    finish_div("hold");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle integer divider for DIV/DIVU, sitting beside the execute stage.
- The execute stage issues operands and a start request, holds a pipeline stall until `ready_o` is high, then writes `result_o` to HI/LO through its HI/LO write path.
- HI receives the remainder and LO receives the quotient.
- Implemented as a radix-2 restoring divider taking one quotient bit per cycle.

Parameters:
- DATA_W, 32: operand width. Only 32 is supported; the counter width is fixed at 6 bits.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high (`RstEnable`)
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU (unsigned)
- opdata1_i  in  32  dividend (rs)
- opdata2_i  in  32  divisor (rt)
- start_i  in  1  divide request (`DivStart`/`DivStop`); held high by execute until the result is consumed
- annul_i  in  1  cancel the in-flight divide (flush, e.g. branch delay or exception)
- result_o  out  64  {remainder, quotient}
- ready_o  out  1  `DivResultReady` when result_o is valid

Behaviour:
- Reset (async, any state): state=DivFree, cnt=0, result_o=0, ready_o=`DivResultNotReady`. All internal regs are cleared.
- States: DivFree, DivByZero, DivOn, DivEnd (2-bit encoding).
- DivFree:
  - start_i=1 and annul_i=0 and opdata2_i==0: go to DivByZero.
  - start_i=1 and annul_i=0 and opdata2_i!=0: go to DivOn. Latch signed_div_i, the operand sign bits, |op1| and |op2| (two's-complement negate when signed and MSB set). Load the 65-bit work reg with {32'b0, |op1|, 1'b0}; cnt=0.
  - Otherwise: stay. ready_o=0, result_o=0.
- Operands are latched at start. Changes on opdata*_i or signed_div_i afterwards are ignored.
- DivOn, per cycle:
  - If annul_i=1: go to DivFree; ready_o stays 0.
  - Else if cnt<32: compute trial = work[63:32] - {1'b0, |op2|} as 33-bit.
    - trial[32]=1 (negative): work <= work << 1.
    - Otherwise: work <= {trial[31:0], work[31:0], 1'b1}.
    - cnt <= cnt+1.
  - Else (cnt==32): quotient = work[31:0] and remainder = work[64:33].
    - If signed and sign1^sign2, negate the quotient.
    - If signed and sign1, negate the remainder.
    - result_o <= {rem, quot}, ready_o <= 1, go to DivEnd.
- DivByZero:
  - If annul_i=1: go to DivFree.
  - Else: result_o <= 0, ready_o <= 1, go to DivEnd.
- DivEnd:
  - Hold result_o and ready_o while start_i=1; annul_i is ignored here.
  - When start_i=0: go to DivFree, ready_o <= 0, result_o <= 0.
- Latency, counting the edge that samples start_i as edge 1:
  - Nonzero divisor: ready_o is high after edge 34.
  - Zero divisor: ready_o is high after edge 2.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. This is deterministic; no trap.
- Back-to-back divides: a new start is accepted only from DivFree. Execute must drop start_i for at least one cycle between divides.
- A reset mid-divide aborts immediately with no partial result visible.

Decomposition:
- Add to defines.v:
  - DivFree/DivByZero/DivOn/DivEnd state codes.
  - DivResultReady/NotReady, DivStart/DivStop.
  - `DoubleRegBus`, `RegBus` (already present).
- Single module. The trial-subtract datapath is one combinational expression, so no sub-module is needed.
- Execute-stage additions (separate change):
  - div_opdata*, div_start, signed_div outputs.
  - stallreq_for_div asserted while DIV/DIVU is active and ready_o=0.

Test Plan:
- Unsigned: DIVU 0xFFFFFFFF / 0x00000010, start held → ready_o rises after edge 34; result_o = {0x0000000F, 0x0FFFFFFF}.
- Signed: DIV 0xFFFFFFF9 (-7) / 0x00000002 → result_o = {0xFFFFFFFF, 0xFFFFFFFD}. Also check 7 / -2 → {0x00000001, 0xFFFFFFFD}.
- Divide by zero: DIV 0x12345678 / 0 → ready_o after edge 2, result_o = 0. start_i low next cycle → ready_o=0 one edge later.
- Annul: start DIVU 100/7, assert annul_i at edge 10 → state DivFree, ready_o never rises. A fresh 100/7 then returns {0x2, 0xE} after 34 edges.
- Async reset: assert rst between clock edges at edge 20 of a divide → result_o=0 and ready_o=0 immediately, without waiting for a clock edge. After release, a new divide of 0x80000000 / 0xFFFFFFFF (signed) → {0x00000000, 0x80000000}.
- Hold: keep start_i high for 5 cycles in DivEnd → result_o stable and ready_o=1 throughout. Operand changes during DivOn do not alter the result.
